sopc_mem_arbiter: RTL and testbench
===================================

SOPC_MEM_ARBITER -- requirements
Module: sopc_mem_arbiter

Interface
REQ-001: Parameter NUM_MASTERS, default 2, is the number of requesting bus masters (range 1..8); master 0 is the instruction bus and master 1 is the data bus.
REQ-002: Parameter ADDR_WIDTH, default 32, is the address width.
REQ-003: Parameter DATA_WIDTH, default 32, is the data width; MASK_WIDTH = DATA_WIDTH/8.
REQ-004: Parameter MEM_BASE, default 32'h8000_0000, is the value subtracted from master addresses to form memory addresses.
REQ-005: Parameter TIMEOUT_CYCLES, default 16, is the BUSY-cycle limit, used only when ARB_TIMEOUT_EN is defined.
REQ-006: clk  in  1  sole clock; all state updates on the rising edge.
REQ-007: rst  in  1  asynchronous, active-high reset.
REQ-008: m_req  in  NUM_MASTERS  per-master request, held high until that master's m_ready.
REQ-009: m_we  in  NUM_MASTERS  per-master write enable.
REQ-010: m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master byte address; master i occupies slice i.
REQ-011: m_wdata  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
REQ-012: m_mask  in  NUM_MASTERS*MASK_WIDTH  per-master byte-lane mask.
REQ-013: m_rdata  out  NUM_MASTERS*DATA_WIDTH  per-master read data, registered.
REQ-014: m_ready  out  NUM_MASTERS  one-cycle completion pulse per master.
REQ-015: m_err  out  NUM_MASTERS  error flag, valid with m_ready.
REQ-016: mem_req  out  1  memory request.
REQ-017: mem_we  out  1  memory write enable.
REQ-018: mem_addr  out  ADDR_WIDTH  memory address.
REQ-019: mem_wdata  out  DATA_WIDTH  memory write data.
REQ-020: mem_mask  out  MASK_WIDTH  memory byte-lane mask.
REQ-021: mem_rdata  in  DATA_WIDTH  memory read data, sampled on the mem_ack cycle.
REQ-022: mem_ack  in  1  memory completion strobe.

Function
REQ-023: The FSM shall have the states IDLE, BUSY and DONE.
REQ-024: In IDLE with any m_req high, the block shall grant one master by round-robin, searching from (last_grant+1) mod NUM_MASTERS.
REQ-025: On the grant, the block shall latch that master's we/addr/wdata/mask and enter BUSY.
REQ-026: In BUSY, mem_req shall be 1 and mem_we/mem_addr/mem_wdata/mem_mask shall drive the latched values.
REQ-027: mem_addr shall equal latched addr minus MEM_BASE, modulo 2^ADDR_WIDTH (wrap-around with no error).
REQ-028: In BUSY with mem_ack=1, the block shall capture mem_rdata into the granted master's m_rdata slice (reads only; writes leave it unchanged) and enter DONE.
REQ-029: In DONE, m_ready[grant] shall be 1 for exactly one cycle, last_grant shall be updated to grant, and the FSM shall return to IDLE.
REQ-030: Minimum latency is 3 cycles from m_req sampled high to m_ready when mem_ack is high on the first BUSY cycle.
REQ-031: mem_ack in IDLE or DONE shall be ignored.
REQ-032: Requests arriving while BUSY or DONE shall wait; no request is dropped.
REQ-033: With all masters continuously requesting, no master shall wait more than NUM_MASTERS transactions.
REQ-034: Outside BUSY, mem_req shall be 0 and the other mem_* outputs shall be 0.

Reset
REQ-035: On rst=1, the FSM shall enter IDLE immediately regardless of clock, including mid-transaction; the in-flight transaction is abandoned with no m_ready.
REQ-036: During reset, m_rdata, m_ready, m_err, mem_req, mem_we, mem_addr, mem_wdata and mem_mask shall all be 0.
REQ-037: last_grant shall reset to NUM_MASTERS-1, so master 0 wins the first arbitration.

Configuration
REQ-038: With ARB_TIMEOUT_EN defined, a counter shall count BUSY cycles.
REQ-039: With ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without mem_ack shall move the FSM to DONE with m_err[grant]=1 on the m_ready pulse and m_rdata slice=0.
REQ-040: With ARB_TIMEOUT_EN undefined, BUSY shall wait indefinitely for mem_ack and m_err shall be constant 0.

Verification
REQ-041: m_req=2'b11 held, mem_ack=1 always -> grants 0,1,0,1; each m_ready pulse exactly 3 cycles after its IDLE grant.
REQ-042: Master 1 read of 0x8000_0010 with mem_rdata=0x1234_5678 -> mem_addr=0x0000_0010, mem_we=0, m_rdata[63:32]=0x1234_5678 with m_ready=2'b10.
REQ-043: Master 1 write to 0x8000_0004, wdata=0xAABB_CCDD, mask=4'b0011 -> mem_we=1, mem_addr=0x4, mem_mask=4'b0011 for every BUSY cycle.
REQ-044: Master 0 read of 0x0000_0000 -> mem_addr=0x8000_0000 (wrap-around), m_err=0.
REQ-045: rst asserted on the 2nd BUSY cycle with mem_ack=0 -> all outputs 0 at once, no m_ready; after release, master 0 is granted first.
REQ-046: ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, mem_ack held 0 -> after 16 BUSY cycles, m_ready=1 with m_err=1 and m_rdata slice=0.

Source files
------------

// File: rtl/sopc_mem_arbiter.sv
// Round-robin arbiter that funnels NUM_MASTERS bus masters onto a single memory port.
// Optional macro ARB_TIMEOUT_EN aborts a stalled transaction after TIMEOUT_CYCLES with m_err.
module sopc_mem_arbiter #(
    parameter int                    NUM_MASTERS    = 2,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = 32'h8000_0000,
    parameter int                    TIMEOUT_CYCLES = 16,
    localparam int                   MASK_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*MASK_WIDTH-1:0] m_mask,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            m_ready,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [MASK_WIDTH-1:0]             mem_mask,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_ack
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state_r;
    state_t                          next_state_s;
    logic [GW-1:0]                   grant_r;
    logic [GW-1:0]                   last_grant_r;
    logic [GW-1:0]                   pick_s;
    logic [GW-1:0]                   idx_s;
    logic                            any_req_s;
    logic                            timeout_s;
    logic                            mem_req_s;
    logic                            mem_we_s;
    logic [ADDR_WIDTH-1:0]           mem_addr_s;
    logic [DATA_WIDTH-1:0]           mem_wdata_s;
    logic [MASK_WIDTH-1:0]           mem_mask_s;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] rdata_s;
    logic [NUM_MASTERS-1:0]          ready_s;
    logic [NUM_MASTERS-1:0]          err_s;

    // Round-robin search starting one past the most recently served master
    always_comb begin
        pick_s    = '0;
        idx_s     = '0;
        any_req_s = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx_s = GW'((int'(last_grant_r) + k) % NUM_MASTERS);
            if (!any_req_s && m_req[idx_s]) begin
                any_req_s = 1'b1;
                pick_s    = idx_s;
            end else begin
                any_req_s = any_req_s;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_r;

    // BUSY-cycle counter, cleared whenever the FSM leaves BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (state_r == BUSY) begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // The TIMEOUT_CYCLES-th BUSY cycle without an ack ends the transaction
    assign timeout_s = (state_r == BUSY) && !mem_ack &&
                       (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; mem_ack only matters while BUSY
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack || timeout_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; the mem_* registers double as the latched request
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        mem_mask_s  = '0;
        rdata_s     = m_rdata;
        ready_s     = '0;
        err_s       = '0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    mem_req_s   = 1'b1;
                    mem_we_s    = m_we[pick_s];
                    mem_addr_s  = m_addr[pick_s*ADDR_WIDTH +: ADDR_WIDTH] - MEM_BASE;
                    mem_wdata_s = m_wdata[pick_s*DATA_WIDTH +: DATA_WIDTH];
                    mem_mask_s  = m_mask[pick_s*MASK_WIDTH +: MASK_WIDTH];
                end else begin
                    mem_req_s   = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    ready_s[grant_r] = 1'b1;
                    if (!mem_we) begin
                        rdata_s[grant_r*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                    end else begin
                        rdata_s = m_rdata;
                    end
                end else if (timeout_s) begin
                    ready_s[grant_r] = 1'b1;
                    err_s[grant_r]   = 1'b1;
                    rdata_s[grant_r*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else begin
                    mem_req_s   = 1'b1;
                    mem_we_s    = mem_we;
                    mem_addr_s  = mem_addr;
                    mem_wdata_s = mem_wdata;
                    mem_mask_s  = mem_mask;
                end
            end
            DONE:    ready_s = '0;
            default: ready_s = '0;
        endcase
    end

    // Output registers and grant bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_mask     <= '0;
            m_rdata      <= '0;
            m_ready      <= '0;
            m_err        <= '0;
            grant_r      <= '0;
            last_grant_r <= GW'(NUM_MASTERS - 1);
        end else begin
            mem_req   <= mem_req_s;
            mem_we    <= mem_we_s;
            mem_addr  <= mem_addr_s;
            mem_wdata <= mem_wdata_s;
            mem_mask  <= mem_mask_s;
            m_rdata   <= rdata_s;
            m_ready   <= ready_s;
            m_err     <= err_s;
            if (state_r == IDLE && any_req_s) begin
                grant_r <= pick_s;
            end else begin
                grant_r <= grant_r;
            end
            if (state_r == DONE) begin
                last_grant_r <= grant_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed self-checking bench for sopc_mem_arbiter (default parameters, two masters).
// Builds with or without ARB_TIMEOUT_EN; the stall test adapts to the configuration.
module tb_sopc_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_mask;
    logic [63:0] m_rdata;
    logic [1:0]  m_ready;
    logic [1:0]  m_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_chk = 0;
    int n_bad = 0;

    sopc_mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_mask   (m_mask),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_mask (mem_mask),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'h0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'h0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'h0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'h0);
        chk({tag, "_mem_mask"}, 64'(mem_mask), 64'h0);
        chk({tag, "_m_ready"}, 64'(m_ready), 64'h0);
        chk({tag, "_m_err"}, 64'(m_err), 64'h0);
        chk({tag, "_m_rdata"}, m_rdata, 64'h0);
    endtask

    // One single-master transaction starting from IDLE; ack is held high in IDLE and DONE to show it is ignored
    task automatic run_txn(input int m, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           input logic [31:0] rd, input int waits,
                           input logic [31:0] exp_addr, input logic [63:0] exp_rdata);
        m_we = 2'b00;
        m_we[m] = we;
        m_addr[m*32 +: 32] = addr;
        m_wdata[m*32 +: 32] = wdata;
        m_mask[m*4 +: 4] = mask;
        mem_rdata = rd;
        mem_ack = 1'b1;
        m_req = 2'b01 << m;
        step();
        for (int i = 0; i <= waits; i++) begin
            mem_ack = (i == waits);
            chk("busy_req", 64'(mem_req), 64'h1);
            chk("busy_we", 64'(mem_we), 64'(we));
            chk("busy_addr", 64'(mem_addr), 64'(exp_addr));
            chk("busy_wdata", 64'(mem_wdata), 64'(wdata));
            chk("busy_mask", 64'(mem_mask), 64'(mask));
            chk("busy_noready", 64'(m_ready), 64'h0);
            step();
        end
        chk("done_ready", 64'(m_ready), 64'(2'b01 << m));
        chk("done_err", 64'(m_err), 64'h0);
        chk("done_rdata", m_rdata, exp_rdata);
        chk("done_memreq", 64'(mem_req), 64'h0);
        m_req = 2'b00;
        mem_ack = 1'b1;
        step();
        chk("idle_ready", 64'(m_ready), 64'h0);
        chk("idle_memreq", 64'(mem_req), 64'h0);
        chk("idle_addr", 64'(mem_addr), 64'h0);
        mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rr_seq;
        int g;

        rst = 1'b1;
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_mask = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Master 0 read of address 0 wraps to 0x8000_0000
        run_txn(0, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 0,
                32'h8000_0000, 64'h0000_0000_CAFE_F00D);
        // Master 1 read of 0x8000_0010
        run_txn(1, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'h1234_5678, 0,
                32'h0000_0010, 64'h1234_5678_CAFE_F00D);
        // Master 1 write, two stall cycles; read data must stay untouched
        run_txn(1, 1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'b0011, 32'hDEAD_BEEF, 2,
                32'h0000_0004, 64'h1234_5678_CAFE_F00D);

        // Both masters requesting with ack always high: grants alternate 0,1,0,1,0
        rr_seq = 5'b01010;
        m_addr = {32'h8000_0200, 32'h8000_0100};
        m_we = 2'b00;
        m_req = 2'b11;
        mem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = int'(rr_seq[k]);
            mem_rdata = 32'h1000_0000 + 32'(k);
            step();
            chk("rr_addr", 64'(mem_addr), (g == 1) ? 64'h200 : 64'h100);
            chk("rr_busy_ready", 64'(m_ready), 64'h0);
            step();
            chk("rr_ready", 64'(m_ready), (g == 1) ? 64'h2 : 64'h1);
            chk("rr_rdata", 64'(m_rdata[g*32 +: 32]), 64'(32'h1000_0000 + 32'(k)));
            if (k == 4) begin
                m_req = 2'b00;
            end
            step();
            chk("rr_gap_ready", 64'(m_ready), 64'h0);
        end
        mem_ack = 1'b0;

        // Reset on the second BUSY cycle of a master-1 transaction
        m_req = 2'b11;
        step();
        chk("rst_pre_addr", 64'(mem_addr), 64'h200);
        step();
        chk("rst_pre_req", 64'(mem_req), 64'h1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        step();
        chk("rst_hold_ready", 64'(m_ready), 64'h0);
        chk("rst_hold_req", 64'(mem_req), 64'h0);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        step();
        chk("post_rst_grant", 64'(mem_addr), 64'h100);
        step();
        chk("post_rst_ready", 64'(m_ready), 64'h1);
        chk("post_rst_rdata", m_rdata, 64'h0000_0000_5A5A_5A5A);
        m_req = 2'b00;
        mem_ack = 1'b0;
        step();

`ifdef ARB_TIMEOUT_EN
        // Stalled read: the 16th BUSY cycle without ack ends it with an error
        m_addr[31:0] = 32'h8000_0040;
        m_req = 2'b01;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("tmo_busy_req", 64'(mem_req), 64'h1);
            chk("tmo_busy_ready", 64'(m_ready), 64'h0);
            step();
        end
        chk("tmo_ready", 64'(m_ready), 64'h1);
        chk("tmo_err", 64'(m_err), 64'h1);
        chk("tmo_rdata", m_rdata, 64'h0);
        chk("tmo_memreq", 64'(mem_req), 64'h0);
        m_req = 2'b00;
        step();
        chk("tmo_after_ready", 64'(m_ready), 64'h0);
        chk("tmo_after_err", 64'(m_err), 64'h0);
`else
        // Without the timeout a long stall simply waits and completes without error
        run_txn(0, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 32'h0000_0077, 20,
                32'h0000_0040, 64'h0000_0000_0000_0077);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
